// File: rtl/klp32_chk_pkg.sv
// Shared types and helpers for the KLP32 commit checker.
package klp32_chk_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_RUN  = 2'd1,
        CHK_DONE = 2'd2
    } chkState_e;

    localparam int CH_PC   = 0;
    localparam int CH_ALU  = 1;
    localparam int CH_WB   = 2;
    localparam int CH_CTRL = 3;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/klp32_chk_exp_ram.sv
// Expected-value table: one write port per channel entry, asynchronous read of a
// whole step row together with that step's compare mask. Contents are never reset.
module klp32_chk_exp_ram #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          wrAddr,
    input  logic [CW-1:0]          wrCh,
    input  logic [XLEN-1:0]        wrData,
    input  logic [NUM_CH-1:0]      wrMask,
    input  logic [AW-1:0]          rdAddr,
    output logic [NUM_CH*XLEN-1:0] rdRow,
    output logic [NUM_CH-1:0]      rdMask
);

    logic [NUM_CH*XLEN-1:0] rows  [DEPTH];
    logic [NUM_CH-1:0]      masks [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            rows[wrAddr][int'(wrCh)*XLEN +: XLEN] <= wrData;
            masks[wrAddr]                         <= wrMask;
        end
    end

    assign rdRow  = rows[rdAddr];
    assign rdMask = masks[rdAddr];

endmodule

// File: rtl/klp32_commit_checker.sv
// KLP32 commit checker: compares each accepted commit against a preloaded table and
// keeps saturating test/pass counters plus first-failure capture. Option: KLP32_CHK_STOP_ON_FAIL_EN.
module klp32_commit_checker
    import klp32_chk_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_ld_we,
    input  logic [AW-1:0]          i_ld_addr,
    input  logic [CW-1:0]          i_ld_ch,
    input  logic [XLEN-1:0]        i_ld_data,
    input  logic [NUM_CH-1:0]      i_ld_mask,
    input  logic [AW:0]            i_num_steps,
    input  logic                   i_start,
    input  logic                   i_valid,
    input  logic [NUM_CH*XLEN-1:0] i_obs,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_fail,
    output logic [CNT_W-1:0]       o_num_tests,
    output logic [CNT_W-1:0]       o_num_passes,
    output logic [AW-1:0]          o_fail_step,
    output logic [CW-1:0]          o_fail_ch,
    output logic [1:0]             o_dbg_state
);

    chkState_e              state;
    logic [AW-1:0]          step;
    logic [AW-1:0]          lastStep;
    logic [NUM_CH*XLEN-1:0] expRow;
    logic [NUM_CH-1:0]      expMask;
    logic [NUM_CH-1:0]      match;
    logic [NUM_CH-1:0]      mismatch;
    logic                   anyMis;
    logic [CW-1:0]          firstCh;
    logic [CNT_W-1:0]       testsNext;
    logic [CNT_W-1:0]       passesNext;

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [5:0] b);
        logic [CNT_W+5:0] s;
        s = (CNT_W+6)'(a) + (CNT_W+6)'(b);
        return (s > (CNT_W+6)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Table is frozen for the duration of a run so every compare sees the loaded values.
    klp32_chk_exp_ram #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) u_expRam (
        .clk    (clk),
        .we     (i_ld_we && (state != CHK_RUN)),
        .wrAddr (i_ld_addr),
        .wrCh   (i_ld_ch),
        .wrData (i_ld_data),
        .wrMask (i_ld_mask),
        .rdAddr (step),
        .rdRow  (expRow),
        .rdMask (expMask)
    );

    always_comb begin
        match   = '0;
        firstCh = '0;
        for (int c = 0; c < NUM_CH; c++)
            match[c] = (i_obs[c*XLEN +: XLEN] == expRow[c*XLEN +: XLEN]);
        mismatch = expMask & ~match;
        anyMis   = |mismatch;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (mismatch[c]) firstCh = CW'(c);
        testsNext  = satAdd(o_num_tests,  popcount(32'(expMask)));
        passesNext = satAdd(o_num_passes, popcount(32'(expMask & match)));
    end

    // i_valid has no backpressure: a commit is consumed on every cycle with i_valid=1
    // while in RUN, and dropped silently in any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CHK_IDLE;
            step         <= '0;
            lastStep     <= '0;
            o_fail       <= 1'b0;
            o_num_tests  <= '0;
            o_num_passes <= '0;
            o_fail_step  <= '0;
            o_fail_ch    <= '0;
        end else begin
            unique case (state)
                CHK_IDLE, CHK_DONE: begin
                    if (i_start) begin
                        state        <= CHK_RUN;
                        step         <= '0;
                        // num_steps of 0 wraps to DEPTH-1, i.e. a full-depth run.
                        lastStep     <= AW'(i_num_steps - (AW+1)'(1));
                        o_fail       <= 1'b0;
                        o_num_tests  <= '0;
                        o_num_passes <= '0;
                        o_fail_step  <= '0;
                        o_fail_ch    <= '0;
                    end
                end
                CHK_RUN: begin
                    if (i_valid) begin
                        o_num_tests  <= testsNext;
                        o_num_passes <= passesNext;
                        step         <= step + 1'b1;
                        if (anyMis && !o_fail) begin
                            o_fail      <= 1'b1;
                            o_fail_step <= step;
                            o_fail_ch   <= firstCh;
                        end
                        if (step == lastStep) state <= CHK_DONE;
`ifdef KLP32_CHK_STOP_ON_FAIL_EN
                        if (anyMis) state <= CHK_DONE;
`else
`endif
                    end
                end
                default: state <= CHK_IDLE;
            endcase
        end
    end

    assign o_busy      = (state == CHK_RUN);
    assign o_done      = (state == CHK_DONE);
    assign o_dbg_state = state;

endmodule

// File: tb/tb_klp32_commit_checker.sv
// Bench for klp32_commit_checker: table of whole runs plus hand sequences for reset,
// load/start during a run, and counter saturation on a CNT_W=4 twin instance.
module tb_klp32_commit_checker;

    localparam int RES_W = 41;

    logic         clk = 1'b0;
    logic         reset;
    logic         ld_we;
    logic [5:0]   ld_addr;
    logic [1:0]   ld_ch;
    logic [31:0]  ld_data;
    logic [3:0]   ld_mask;
    logic [6:0]   num_steps;
    logic         start;
    logic         valid;
    logic [127:0] obs;

    logic         busy, done, fail;
    logic [15:0]  tests, passes;
    logic [5:0]   fail_step;
    logic [1:0]   fail_ch, dbg;
    logic         busy2, done2, fail2;
    logic [3:0]   tests2, passes2;
    logic [5:0]   fail_step2;
    logic [1:0]   fail_ch2, dbg2;

    logic [31:0]      exp_tab [64][4];
    logic [RES_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;

    typedef struct {
        int       steps;
        logic [3:0] mask;
        int       bad_a;
        logic [3:0] bad_am;
        int       bad_b;
        logic [3:0] bad_bm;
        int       e_tests;
        int       e_passes;
        logic     e_fail;
        int       e_step;
        int       e_ch;
        int       s_tests;
        int       s_passes;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    klp32_commit_checker #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_ch(ld_ch),
        .i_ld_data(ld_data), .i_ld_mask(ld_mask), .i_num_steps(num_steps), .i_start(start),
        .i_valid(valid), .i_obs(obs), .o_busy(busy), .o_done(done), .o_fail(fail),
        .o_num_tests(tests), .o_num_passes(passes), .o_fail_step(fail_step),
        .o_fail_ch(fail_ch), .o_dbg_state(dbg)
    );

    klp32_commit_checker #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_ch(ld_ch),
        .i_ld_data(ld_data), .i_ld_mask(ld_mask), .i_num_steps(num_steps), .i_start(start),
        .i_valid(valid), .i_obs(obs), .o_busy(busy2), .o_done(done2), .o_fail(fail2),
        .o_num_tests(tests2), .o_num_passes(passes2), .o_fail_step(fail_step2),
        .o_fail_ch(fail_ch2), .o_dbg_state(dbg2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic load_and_start(input int steps, input logic [3:0] mask);
        for (int s = 0; s < steps; s++) begin
            for (int c = 0; c < 4; c++) begin
                exp_tab[s][c] = $urandom;
                @(negedge clk);
                ld_we     = 1'b1;
                ld_addr   = 6'(s);
                ld_ch     = 2'(c);
                ld_data   = exp_tab[s][c];
                ld_mask   = mask;
                num_steps = (steps == 64) ? 7'd0 : 7'(steps);
                start     = (s == steps - 1) && (c == 3);
            end
        end
        @(negedge clk);
        ld_we = 1'b0;
        start = 1'b0;
    endtask

    task automatic drive_steps(input int steps, input int bad_a, input logic [3:0] am,
                               input int bad_b, input logic [3:0] bm, input int gaps);
        logic [31:0] v;
        for (int s = 0; s < steps; s++) begin
            repeat ($urandom_range(0, gaps)) begin
                @(negedge clk);
                valid = 1'b0;
            end
            @(negedge clk);
            if (done) break;
            valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                v = exp_tab[s][c];
                if (s == bad_a && am[c]) v = v ^ 32'h1;
                if (s == bad_b && bm[c]) v = v ^ 32'h1;
                obs[c*32 +: 32] = v;
            end
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("run_done", done, 1);
        check("run_done_sat", done2, 1);
        check("dbg_state_done", dbg, 2);
    endtask

    task automatic compare_result();
        logic [RES_W-1:0] r;
        int et, ep;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: result with empty expected queue");
        end else begin
            r  = exp_q.pop_front();
            et = int'(r[40:25]);
            ep = int'(r[24:9]);
            check("num_tests",   tests, r[40:25]);
            check("num_passes",  passes, r[24:9]);
            check("fail_flag",   fail, r[8]);
            check("fail_step",   fail_step, r[7:2]);
            check("fail_ch",     fail_ch, r[1:0]);
            check("sat_tests",   tests2, (et > 15) ? 15 : et);
            check("sat_passes",  passes2, (ep > 15) ? 15 : ep);
            check("sat_fail",    fail2, r[8]);
            check("sat_fstep",   fail_step2, r[7:2]);
            check("sat_fch",     fail_ch2, r[1:0]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int et, ep;
        //        steps mask  a   am     b   bm     t   p   f     fs fc  st  sp
        vecs[0] = '{3,  4'hF, -1, 4'h0, -1, 4'h0, 12, 12, 1'b0, 0, 0, 12, 12};
        vecs[1] = '{3,  4'hF,  1, 4'h4,  2, 4'h1, 12, 10, 1'b1, 1, 2,  8,  7};
        vecs[2] = '{12, 4'h4, -1, 4'h0, -1, 4'h0, 12, 12, 1'b0, 0, 0, 12, 12};
        vecs[3] = '{5,  4'hF,  3, 4'hA, -1, 4'h0, 20, 18, 1'b1, 3, 1, 16, 14};
        vecs[4] = '{4,  4'hA,  2, 4'h5, -1, 4'h0,  8,  8, 1'b0, 0, 0,  8,  8};
        vecs[5] = '{64, 4'h1, -1, 4'h0, -1, 4'h0, 64, 64, 1'b0, 0, 0, 64, 64};
        vecs[6] = '{2,  4'h0,  0, 4'hF, -1, 4'h0,  0,  0, 1'b0, 0, 0,  0,  0};
        vecs[7] = '{5,  4'hF, -1, 4'h0, -1, 4'h0, 20, 20, 1'b0, 0, 0, 20, 20};

        reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_ch = '0; ld_data = '0; ld_mask = '0;
        num_steps = '0; start = 1'b0; valid = 1'b0; obs = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_tests", tests, 0);
        check("rst_passes", passes, 0);
        check("rst_fstep", fail_step, 0);
        check("rst_fch", fail_ch, 0);
        check("rst_dbg", dbg, 0);

        for (int v = 0; v < 8; v++) begin
            load_and_start(vecs[v].steps, vecs[v].mask);
            check("busy_after_start", busy, 1);
            check("busy_after_start_sat", busy2, 1);
`ifdef KLP32_CHK_STOP_ON_FAIL_EN
            et = vecs[v].s_tests;
            ep = vecs[v].s_passes;
`else
            et = vecs[v].e_tests;
            ep = vecs[v].e_passes;
`endif
            exp_q.push_back({16'(et), 16'(ep), vecs[v].e_fail, 6'(vecs[v].e_step), 2'(vecs[v].e_ch)});
            drive_steps(vecs[v].steps, vecs[v].bad_a, vecs[v].bad_am, vecs[v].bad_b, vecs[v].bad_bm, 3);
            wait_done();
            compare_result();
        end

        // Reset in the middle of a 4-step run, then rerun from the retained table.
        load_and_start(4, 4'hF);
        for (int s = 0; s < 2; s++) begin
            valid = 1'b1;
            for (int c = 0; c < 4; c++) obs[c*32 +: 32] = exp_tab[s][c];
            @(negedge clk);
        end
        valid = 1'b0;
        check("midrun_tests", tests, 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_tests", tests, 0);
        check("midrst_passes", passes, 0);
        check("midrst_dbg", dbg, 0);
        num_steps = 7'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back({16'd16, 16'd16, 1'b0, 6'd0, 2'd0});
        drive_steps(4, -1, 4'h0, -1, 4'h0, 2);
        wait_done();
        compare_result();

        // Table write and start during RUN must both be ignored.
        load_and_start(3, 4'hF);
        exp_q.push_back({16'd12, 16'd12, 1'b0, 6'd0, 2'd0});
        ld_we = 1'b1; ld_addr = 6'd2; ld_ch = 2'd0; ld_data = ~exp_tab[2][0]; ld_mask = 4'h0;
        start = 1'b1; num_steps = 7'd1;
        @(negedge clk);
        ld_we = 1'b0; start = 1'b0;
        drive_steps(3, -1, 4'h0, -1, 4'h0, 2);
        wait_done();
        compare_result();

        // Commits presented while DONE are dropped.
        repeat (3) begin
            valid = 1'b1;
            obs = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        valid = 1'b0;
        check("idle_valid_tests", tests, 12);
        check("idle_valid_passes", passes, 12);
        check("idle_valid_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
